// File: rtl/alu_arbiter.sv
// Two requesters share one combinational ALU through a round-robin grant.
// The selected result, flags and requester id sit in a one-entry response register.
module alu_arbiter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [2:0]       req0_f,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [2:0]       req1_f,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_y,
   output logic [2:0]       rsp_t,
   output logic             rsp_id
);

   // Handshake: a transfer happens on any rising edge where valid && ready are both
   // high; the sender holds payload stable until then, and ready never looks at payload.

   logic             prio;
   logic             accept;
   logic             grant0;
   logic             grant1;
   logic             xfer;
   logic             gnt_id;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [2:0]       op_f;
   logic [WIDTH-1:0] alu_y;
   logic [2:0]       alu_t;

   // Grant and ready: depend only on valids, prio and the response slot state.
   always_comb begin
      accept     = !rsp_valid || rsp_ready;
      grant0     = req0_valid && (!req1_valid || !prio);
      grant1     = req1_valid && (!req0_valid || prio);
      req0_ready = grant0 && accept && !rst;
      req1_ready = grant1 && accept && !rst;
      xfer       = req0_ready || req1_ready;
      gnt_id     = grant1;
   end

   always_comb begin
      op_a = grant1 ? req1_a : req0_a;
      op_b = grant1 ? req1_b : req0_b;
      op_f = grant1 ? req1_f : req0_f;
   end

   // Shifts use the full unsigned b; the language semantics already give 0
   // (or all sign bits for >>>) once b reaches WIDTH.
   always_comb begin
      alu_y = '0;
      alu_t = 3'b000;
      case (op_f)
         3'd0: begin
            alu_y = op_a - op_b;
            alu_t = {op_a < op_b, $signed(op_a) < $signed(op_b), op_a == op_b};
         end
         3'd1: alu_y = op_a + op_b;
         3'd2: alu_y = op_a & op_b;
         3'd3: alu_y = op_a | op_b;
         3'd4: alu_y = op_a ^ op_b;
         3'd5: alu_y = op_a >> op_b;
         3'd6: alu_y = op_a << op_b;
         3'd7: alu_y = $unsigned($signed(op_a) >>> op_b);
         default: alu_y = '0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_valid <= 1'b0;
         rsp_y     <= '0;
         rsp_t     <= 3'b000;
         rsp_id    <= 1'b0;
         prio      <= 1'b0;
      end else if (xfer) begin
         rsp_valid <= 1'b1;
         rsp_y     <= alu_y;
         rsp_t     <= alu_t;
         rsp_id    <= gnt_id;
         prio      <= ~gnt_id;
      end else if (rsp_ready) begin
         rsp_valid <= 1'b0;
      end
   end

endmodule
